cp0_irq_unit: RTL and testbench

- Parametrised next-generation coprocessor-0 register file.
- Adds a Count/Compare timer with a timer interrupt, sampled hardware interrupt lines and software interrupts, and an interrupt-request output to the commit stage.
- Keeps MTC0/MFC0, exception entry and ERET handling.
- Sits beside the commit/writeback stage; the exception arbiter drives it and the fetch redirect consumes it.

---
 rtl/cp0_pkg.sv | 56 +++++
 rtl/cp0_timer.sv | 58 +++++
 rtl/cp0_irq_unit.sv | 169 ++++++++++++++++
 tb/tb_cp0_irq_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 register file: register
// addresses, exception codes, Status/Cause bit positions and write masks,
// and packed views of Status and Cause.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_CONFIG   = 5'd16;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;
  localparam int ST_BEV = 22;
  localparam int CA_TI  = 30;
  localparam int CA_BD  = 31;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0004;
  // IM[15:8], ERL, EXL, IE
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF07;
  // software interrupt bits IP[1:0]
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef struct packed {
    logic [8:0] rsv_hi;   // 31:23
    logic       bev;      // 22
    logic [5:0] rsv_mid;  // 21:16
    logic [7:0] im;       // 15:8
    logic [4:0] rsv_lo;   // 7:3
    logic       erl;      // 2
    logic       exl;      // 1
    logic       ie;       // 0
  } status_t;

  typedef struct packed {
    logic        bd;        // 31
    logic        ti;        // 30
    logic [13:0] rsv_hi;    // 29:16
    logic [7:0]  ip;        // 15:8
    logic        rsv_mid;   // 7
    logic [4:0]  exc_code;  // 6:2
    logic [1:0]  rsv_lo;    // 1:0
  } cause_t;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0.
// Ports: clk, reset (async, active-high); count_we/compare_we load wd into
// Count/Compare; count, compare are the current register values; ti is the
// timer interrupt flag (Cause.TI).
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wd,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

  logic [3:0] div;
  logic       tick;

  assign tick = (div == DIV_LAST);

  // A Count write restarts the prescaler so the loaded value holds for a
  // full COUNT_DIV period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div   <= 4'd0;
      count <= 32'd0;
    end else if (count_we) begin
      div   <= 4'd0;
      count <= wd;
    end else if (tick) begin
      div   <= 4'd0;
      count <= count + 32'd1;
    end else begin
      div   <= div + 4'd1;
    end
  end

  // Compare == 0 disables the match so a freshly reset timer stays quiet.
  // A Compare write acknowledges TI and beats a coincident match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      if (compare_we)
        compare <= wd;
      if (compare_we)
        ti <= 1'b0;
      else if ((count == compare) && (compare != 32'd0))
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_irq_unit.sv
// Coprocessor-0 register file with Count/Compare timer, synchronised
// hardware interrupts, software interrupts and an interrupt request to the
// commit stage.
// Ports: clk, reset (async, active-high); ra/rd MFC0 read (combinational);
// we/wa/wd MTC0 write; exc_* exception commit; eret; hw_int external
// level interrupts; int_req pending+enabled interrupt; epc_o/status_o/
// cause_o current register values.
// Build option: define CP0_WRITE_FORWARD_EN to forward a same-cycle MTC0
// to an MFC0 of the same register.
module cp0_irq_unit
  import cp0_pkg::*;
#(
  parameter int          HW_IRQ_NUM  = 6,
  parameter int          COUNT_DIV   = 2,
  parameter int          TIMER_IP    = 7,
  parameter logic [31:0] CONFIG_INIT = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            ra,
  output logic [31:0]           rd,
  input  logic                  we,
  input  logic [4:0]            wa,
  input  logic [31:0]           wd,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_in_ds,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  input  logic [HW_IRQ_NUM-1:0] hw_int,
  output logic                  int_req,
  output logic [31:0]           epc_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o
);

  status_t                 status_q;
  logic [31:0]             epc_q;
  logic [31:0]             badvaddr_q;
  logic                    bd_q;
  logic [4:0]              exc_code_q;
  logic [1:0]              ip_sw_q;
  logic [HW_IRQ_NUM-1:0]   hw_sync1, hw_sync2, ip_hw_q;
  logic [31:0]             count, compare;
  logic                    ti;
  logic [7:0]              ip;
  cause_t                  cause_v;
  logic [31:0]             rd_reg;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (we && (wa == CP0_COUNT)),
    .compare_we (we && (wa == CP0_COMPARE)),
    .wd         (wd),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Two-flop synchroniser, then the Cause.IP load stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hw_sync1 <= '0;
      hw_sync2 <= '0;
      ip_hw_q  <= '0;
    end else begin
      hw_sync1 <= hw_int;
      hw_sync2 <= hw_sync1;
      ip_hw_q  <= hw_sync2;
    end
  end

  // Sources are applied lowest priority first (MTC0, ERET, exception) so a
  // later assignment to the same field overrides an earlier one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q   <= status_t'(STATUS_RESET);
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      ip_sw_q    <= 2'd0;
    end else begin
      if (we && (wa == CP0_STATUS)) begin
        status_q.im  <= wd[15:8];
        status_q.erl <= wd[ST_ERL];
        status_q.exl <= wd[ST_EXL];
        status_q.ie  <= wd[ST_IE];
      end
      if (we && (wa == CP0_CAUSE))
        ip_sw_q <= wd[9:8];
      if (we && (wa == CP0_EPC))
        epc_q <= wd;

      if (eret) begin
        if (status_q.erl)
          status_q.erl <= 1'b0;
        else
          status_q.exl <= 1'b0;
      end

      if (exc_valid) begin
        // A nested exception keeps the original return point.
        if (!status_q.exl) begin
          epc_q <= exc_in_ds ? (exc_pc - 32'd4) : exc_pc;
          bd_q  <= exc_in_ds;
        end
        exc_code_q   <= exc_code;
        status_q.exl <= 1'b1;
        if ((exc_code == CODE_ADEL) || (exc_code == CODE_ADES))
          badvaddr_q <= exc_badvaddr;
      end
    end
  end

  always_comb begin
    ip              = 8'd0;
    ip[1:0]         = ip_sw_q;
    ip[2 +: HW_IRQ_NUM] = ip_hw_q;
    ip[TIMER_IP]    = ip[TIMER_IP] | ti;
  end

  always_comb begin
    cause_v          = '0;
    cause_v.bd       = bd_q;
    cause_v.ti       = ti;
    cause_v.ip       = ip;
    cause_v.exc_code = exc_code_q;
  end

  assign status_o = status_q;
  assign cause_o  = cause_v;
  assign epc_o    = epc_q;
  assign int_req  = status_q.ie & ~status_q.exl & ~status_q.erl & (|(ip & status_q.im));

  always_comb begin
    case (ra)
      CP0_BADVADDR: rd_reg = badvaddr_q;
      CP0_COUNT:    rd_reg = count;
      CP0_COMPARE:  rd_reg = compare;
      CP0_STATUS:   rd_reg = status_o;
      CP0_CAUSE:    rd_reg = cause_o;
      CP0_EPC:      rd_reg = epc_q;
      CP0_CONFIG:   rd_reg = CONFIG_INIT;
      default:      rd_reg = 32'd0;
    endcase
  end

`ifdef CP0_WRITE_FORWARD_EN
  // Only the MTC0 contribution is forwarded; read-only bits keep their
  // registered value.
  always_comb begin
    rd = rd_reg;
    if (we && (wa == ra)) begin
      case (wa)
        CP0_COUNT, CP0_COMPARE, CP0_EPC: rd = wd;
        CP0_STATUS: rd = (status_o & ~STATUS_WMASK) | (wd & STATUS_WMASK);
        CP0_CAUSE:  rd = (cause_o & ~CAUSE_WMASK) | (wd & CAUSE_WMASK);
        default:    rd = rd_reg;
      endcase
    end
  end
`else
  assign rd = rd_reg;
`endif

endmodule

// File: tb/tb_cp0_irq_unit.sv
module tb_cp0_irq_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ra = 5'd0;
  logic [31:0] rd;
  logic        we = 1'b0;
  logic [4:0]  wa = 5'd0;
  logic [31:0] wd = 32'd0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic [31:0] exc_pc = 32'd0;
  logic        exc_in_ds = 1'b0;
  logic [31:0] exc_badvaddr = 32'd0;
  logic        eret = 1'b0;
  logic [5:0]  hw_int = 6'd0;
  logic        int_req;
  logic [31:0] epc_o, status_o, cause_o;

  int n_cmp = 0;
  int n_err = 0;

  cp0_irq_unit dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_in_ds(exc_in_ds), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .hw_int(hw_int), .int_req(int_req), .epc_o(epc_o),
    .status_o(status_o), .cause_o(cause_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    we = 1'b0; exc_valid = 1'b0; eret = 1'b0; hw_int = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    step();
    we = 1'b0;
  endtask

  task automatic mfc0_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    ra = a;
    #1;
    check(name, rd, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'h0,         5'd12, 32'h0040_0004, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         5'd13, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         5'd14, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd8,  32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         5'd11, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF07, 1'b0};
    vecs[6]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300, 1'b0};
    vecs[7]  = '{1'b1, 5'd12, 32'h0000_0101, 5'd12, 32'h0040_0101, 1'b1};
    vecs[8]  = '{1'b1, 5'd12, 32'h0000_0201, 5'd12, 32'h0040_0201, 1'b1};
    vecs[9]  = '{1'b1, 5'd12, 32'h0000_0203, 5'd12, 32'h0040_0203, 1'b0};
    vecs[10] = '{1'b1, 5'd12, 32'h0000_0201, 5'd12, 32'h0040_0201, 1'b1};
    vecs[11] = '{1'b1, 5'd13, 32'h0000_0100, 5'd13, 32'h0000_0100, 1'b0};
    vecs[12] = '{1'b1, 5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b1, 5'd14, 32'hDEAD_BEEC, 5'd14, 32'hDEAD_BEEC, 1'b0};
    vecs[14] = '{1'b1, 5'd11, 32'h5555_0000, 5'd11, 32'h5555_0000, 1'b0};
    vecs[15] = '{1'b1, 5'd8,  32'h0000_FFFF, 5'd8,  32'h0000_0000, 1'b0};
    vecs[16] = '{1'b1, 5'd16, 32'h0000_0000, 5'd16, 32'h8000_0000, 1'b0};
    vecs[17] = '{1'b1, 5'd9,  32'h0000_0100, 5'd9,  32'h0000_0100, 1'b0};
    vecs[18] = '{1'b0, 5'd0,  32'h0,         5'd0,  32'h0000_0000, 1'b0};
    vecs[19] = '{1'b0, 5'd0,  32'h0,         5'd15, 32'h0000_0000, 1'b0};
    vecs[20] = '{1'b0, 5'd0,  32'h0,         5'd31, 32'h0000_0000, 1'b0};

    do_reset();
    check("reset int_req", {31'd0, int_req}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd; ra = vecs[i].ra;
      step();
      we = 1'b0;
      #1;
      check($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d int_req", i), {31'd0, int_req}, {31'd0, vecs[i].exp_irq});
    end

    // Timer: Count written at edge E0, Compare at E1, TI sets at E21,
    // Compare write at E22 coincides with the match and clears TI.
    do_reset();
    mtc0(5'd12, 32'h0000_8001);
    check("timer status", status_o, 32'h0040_8001);
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd10);
    repeat (19) @(posedge clk);
    #1;
    mfc0_check("timer count@E20", 5'd9, 32'd10);
    check("timer TI@E20", {31'd0, cause_o[30]}, 32'd0);
    check("timer irq@E20", {31'd0, int_req}, 32'd0);
    step();
    check("timer TI@E21", {31'd0, cause_o[30]}, 32'd1);
    check("timer IP7@E21", {31'd0, cause_o[15]}, 32'd1);
    check("timer irq@E21", {31'd0, int_req}, 32'd1);
    mtc0(5'd11, 32'h5555_0000);
    check("timer TI cleared", {31'd0, cause_o[30]}, 32'd0);
    check("timer irq cleared", {31'd0, int_req}, 32'd0);
    mfc0_check("timer count@E22", 5'd9, 32'd11);

    // Hardware interrupt through synchroniser.
    do_reset();
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'd1;
    step();
    step();
    check("hw IP2 after 2", {31'd0, cause_o[10]}, 32'd0);
    check("hw irq after 2", {31'd0, int_req}, 32'd0);
    step();
    check("hw IP2 after 3", {31'd0, cause_o[10]}, 32'd1);
    check("hw irq after 3", {31'd0, int_req}, 32'd1);
    hw_int = 6'd0;
    mtc0(5'd12, 32'h0000_0403);
    hw_int = 6'd1;
    repeat (3) step();
    check("hw IP2 with EXL", {31'd0, cause_o[10]}, 32'd1);
    check("hw irq with EXL", {31'd0, int_req}, 32'd0);
    hw_int = 6'd0;

    // Delay-slot exception.
    do_reset();
    mtc0(5'd12, 32'h0000_0000);
    exc_valid = 1'b1; exc_in_ds = 1'b1; exc_pc = 32'hBFC0_0104;
    exc_code = 5'd4; exc_badvaddr = 32'h1;
    step();
    exc_valid = 1'b0;
    check("ds EPC", epc_o, 32'hBFC0_0100);
    check("ds BD", {31'd0, cause_o[31]}, 32'd1);
    check("ds ExcCode", {27'd0, cause_o[6:2]}, 32'd4);
    check("ds EXL", {31'd0, status_o[1]}, 32'd1);
    mfc0_check("ds BadVAddr", 5'd8, 32'h1);

    // Nested exception while EXL=1.
    exc_valid = 1'b1; exc_in_ds = 1'b0; exc_pc = 32'h8000_0180;
    exc_code = 5'd8; exc_badvaddr = 32'hFFFF_FFFF;
    step();
    exc_valid = 1'b0;
    check("nest EPC", epc_o, 32'hBFC0_0100);
    check("nest BD", {31'd0, cause_o[31]}, 32'd1);
    check("nest ExcCode", {27'd0, cause_o[6:2]}, 32'd8);
    mfc0_check("nest BadVAddr", 5'd8, 32'h1);

    // ERET clears EXL; then an AdES exception outside a delay slot.
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("eret EXL", status_o, 32'h0040_0000);
    exc_valid = 1'b1; exc_in_ds = 1'b0; exc_pc = 32'h0000_0400;
    exc_code = 5'd5; exc_badvaddr = 32'h44;
    step();
    exc_valid = 1'b0;
    check("ades EPC", epc_o, 32'h0000_0400);
    check("ades BD", {31'd0, cause_o[31]}, 32'd0);
    mfc0_check("ades BadVAddr", 5'd8, 32'h44);

    // Exception and MTC0 Status in the same cycle.
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h900;
    we = 1'b1; wa = 5'd12; wd = 32'h0000_FF01;
    step();
    exc_valid = 1'b0; we = 1'b0;
    check("conflict status", status_o, 32'h0040_FF03);
    check("conflict EPC", epc_o, 32'h0000_0400);
    mtc0(5'd12, 32'h0000_0006);
    eret = 1'b1;
    step();
    eret = 1'b0;
    check("eret ERL", status_o, 32'h0040_0002);

    // Same-cycle MTC0/MFC0 of EPC.
    we = 1'b1; wa = 5'd14; wd = 32'h1234; ra = 5'd14;
    #1;
`ifdef CP0_WRITE_FORWARD_EN
    check("fwd rd", rd, 32'h0000_1234);
`else
    check("fwd rd", rd, 32'h0000_0400);
`endif
    @(posedge clk);
    #1;
    we = 1'b0;
    check("fwd EPC after", epc_o, 32'h0000_1234);

    // Asynchronous reset mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    check("async rst status", status_o, 32'h0040_0004);
    check("async rst EPC", epc_o, 32'h0);
    step();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
